// File: rtl/keyboard_line_editor.sv
// keyboard_line_editor: assembles key events into an editable line and streams it out on enter. Optional REPEAT_FILTER_EN drops auto-repeats.
module keyboard_line_editor #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6,
  parameter int HOLDOFF = 2500000
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  input  logic             key_pressed,
  input  logic [7:0]       keycode,
  input  logic             clear,
  output logic [7:0]       out_char,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [LEN_W-1:0] line_len,
  output logic             busy,
  output logic             nav_up,
  output logic             nav_down,
  output logic             dropped
);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
  typedef enum logic {EDIT, DRAIN} state_t;
  state_t           state_q;
  logic [7:0]       mem_q [MAX_LEN];
  logic [LEN_W-1:0] len_q, rd_ptr_q;
  logic             nav_up_q, nav_down_q, dropped_q;
  logic             key_ev, is_print, is_last, wr_en;
  if (MAX_LEN < 2 || (2 ** LEN_W) <= MAX_LEN || HOLDOFF < 0) begin : g_bad_params
    $error("keyboard_line_editor: illegal MAX_LEN/LEN_W/HOLDOFF combination");
  end
`ifdef REPEAT_FILTER_EN
  localparam int HW = $clog2(HOLDOFF + 2);
  logic [7:0]    last_q;
  logic [HW-1:0] hold_q;
  logic          filt;
  assign filt = key_pressed && keycode == last_q && hold_q != '0;
  // holdoff window restarts on every event that gets past the filter, then counts down to zero
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) begin
      last_q <= '0;
      hold_q <= '0;
    end else if (key_pressed && !clear && !filt) begin
      last_q <= keycode;
      hold_q <= HW'(HOLDOFF);
    end else if (hold_q != '0) hold_q <= hold_q - HW'(1);
  assign key_ev = key_pressed && !filt;
`else
  assign key_ev = key_pressed;
`endif
  assign is_print = keycode <= 8'd36 || keycode == 8'd38;
  assign is_last  = rd_ptr_q == len_q - LEN_W'(1);
  assign wr_en    = !clear && state_q == EDIT && key_ev && is_print && len_q != MAX_L;
  // line storage; contents are meaningless until written so no reset is needed
  always_ff @(posedge CLOCK_50)
    if (wr_en) mem_q[len_q[AW-1:0]] <= keycode;
  // EDIT/DRAIN controller with registered length, read pointer and pulse outputs
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) begin
      state_q    <= EDIT;
      len_q      <= '0;
      rd_ptr_q   <= '0;
      nav_up_q   <= 1'b0;
      nav_down_q <= 1'b0;
      dropped_q  <= 1'b0;
    end else begin
      nav_up_q   <= 1'b0;
      nav_down_q <= 1'b0;
      dropped_q  <= 1'b0;
      if (clear) begin
        state_q  <= EDIT;
        len_q    <= '0;
        rd_ptr_q <= '0;
      end else if (state_q == DRAIN) begin
        dropped_q <= key_ev;
        if (out_ready && is_last) begin
          state_q  <= EDIT;
          len_q    <= '0;
          rd_ptr_q <= '0;
        end else if (out_ready) rd_ptr_q <= rd_ptr_q + LEN_W'(1);
      end else if (key_ev) begin
        if (is_print) begin
          if (len_q != MAX_L) len_q <= len_q + LEN_W'(1);
          else dropped_q <= 1'b1;
        end else if (keycode == 8'd37) begin
          if (len_q != '0) len_q <= len_q - LEN_W'(1);
        end else if (keycode == 8'd98) begin
          if (len_q != '0) begin
            state_q  <= DRAIN;
            rd_ptr_q <= '0;
          end
        end
        nav_down_q <= keycode == 8'd99;
        nav_up_q   <= keycode == 8'd100;
      end
    end
  assign out_valid = state_q == DRAIN;
  assign busy      = state_q == DRAIN;
  assign out_char  = out_valid ? mem_q[rd_ptr_q[AW-1:0]] : 8'd0;
  assign out_last  = out_valid && is_last;
  assign line_len  = len_q;
  assign nav_up    = nav_up_q;
  assign nav_down  = nav_down_q;
  assign dropped   = dropped_q;
endmodule
